fetch_decode_pipe: RTL

FETCH_DECODE_PIPE -- requirements
Module: fetch_decode_pipe

---
 rtl/fetch_decode_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: single-issue instruction fetch front end feeding a decode
// (ID) register, with field extraction and a register file that provides
// bypassed operand reads.
module fetch_decode_pipe #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_tgt,
    input  logic            stall,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            illegal_reg
);

    // Index width of the physical register array (16 or 32 entries).
    localparam int          IDXW    = (NREGS == 16) ? 4 : 5;
    localparam logic [5:0]  NREGS_W = 6'(NREGS);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_id_pc;
    logic            r_id_valid;
    logic [XLEN-1:0] r_regs [NREGS];

    logic            w_imem_req;
    logic            w_accept;
    logic            w_wr_ok;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // True when a 5-bit register index names an implemented register.
    function automatic logic idx_legal(input logic [4:0] idx);
        return ({1'b0, idx} < NREGS_W);
    endfunction

    // A request goes out only in FETCH and only if the ID slot can take it.
    assign w_imem_req = (r_state == ST_FETCH) && !(r_id_valid && stall);
    // A redirect discards any response arriving in the same cycle.
    assign w_accept   = w_imem_req && imem_valid && !redirect;
    assign w_wr_ok    = wb_en && (wb_rd != 5'd0) && idx_legal(wb_rd);

    assign w_rd  = r_ir[11:7];
    assign w_rs1 = r_ir[19:15];
    assign w_rs2 = r_ir[24:20];

    // Fetch FSM, PC and ID register; redirect outranks acceptance and stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_ir       <= NOP;
            r_id_pc    <= RESET_PC;
        end else begin
            case (r_state)
                ST_BOOT:  r_state <= ST_FETCH;
                ST_FETCH: r_state <= ST_FETCH;
                ST_FLUSH: r_state <= ST_FETCH;
                default:  r_state <= ST_BOOT;
            endcase
            if (redirect) begin
                r_state    <= ST_FLUSH;
                r_pc       <= redirect_tgt;
                r_id_valid <= 1'b0;
            end else if (w_accept) begin
                r_ir       <= imem_rdata;
                r_id_pc    <= r_pc;
                r_id_valid <= 1'b1;
                r_pc       <= r_pc + XLEN'(4);
            end else if (r_id_valid && stall) begin
                r_ir       <= r_ir;
                r_id_pc    <= r_id_pc;
                r_id_valid <= r_id_valid;
                r_pc       <= r_pc;
            end else begin
                r_id_valid <= 1'b0;
            end
        end
    end

    // Register file write port; x0 and unimplemented indices are never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wb_rd[IDXW-1:0]] <= wb_data;
        end
    end

    // rs1 read port with same-cycle write-back bypass.
    always_comb begin
        w_rs1_data = '0;
        if ((w_rs1 == 5'd0) || !idx_legal(w_rs1)) begin
            w_rs1_data = '0;
        end else if (wb_en && (wb_rd == w_rs1)) begin
            w_rs1_data = wb_data;
        end else begin
            w_rs1_data = r_regs[w_rs1[IDXW-1:0]];
        end
    end

    // rs2 read port with same-cycle write-back bypass.
    always_comb begin
        w_rs2_data = '0;
        if ((w_rs2 == 5'd0) || !idx_legal(w_rs2)) begin
            w_rs2_data = '0;
        end else if (wb_en && (wb_rd == w_rs2)) begin
            w_rs2_data = wb_data;
        end else begin
            w_rs2_data = r_regs[w_rs2[IDXW-1:0]];
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign opcode      = r_ir[6:0];
    assign rd          = w_rd;
    assign funct3      = r_ir[14:12];
    assign rs1         = w_rs1;
    assign rs2         = w_rs2;
    assign funct7      = r_ir[31:25];
    assign rs1_data    = w_rs1_data;
    assign rs2_data    = w_rs2_data;
    assign illegal_reg = r_id_valid &&
                         (!idx_legal(w_rd) || !idx_legal(w_rs1) || !idx_legal(w_rs2));

endmodule
